// File: rtl/scaler_snapshot_sequencer.sv
// Walks the scaler map once per PPS, captures each word into a ping-pong buffer and
// presents the last complete snapshot to the host, with sequence and drop/overrun status.
module scaler_snapshot_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned NUM_WORDS     = 19
) (
    input  logic        clk33_i,
    input  logic        rst_n_i,
    input  logic        pps_i,
    output logic [5:0]  scal_addr_o,
    input  logic [31:0] scal_dat_i,
    input  logic        lock_i,
    input  logic [4:0]  rd_addr_i,
    output logic [31:0] rd_dat_o,
    output logic        snap_valid_o,
    output logic [7:0]  snap_seq_o,
    output logic        busy_o,
    output logic        overrun_o,
    output logic [7:0]  drop_cnt_o
);

    typedef enum logic [2:0] {StIdle, StSettle, StAddr, StCapt, StSwap} state_t;

    state_t      state;
    logic        pps_q;
    logic        pps_edge;
    logic [7:0]  settle_cnt;
    logic [4:0]  idx;
    logic [7:0]  seq_cnt;
    logic        vis_bank;
    logic [31:0] mem [64];

    assign pps_edge = pps_i & ~pps_q;

    function automatic logic [5:0] word_addr(input logic [4:0] i);
        if (i < 5'd16) begin
            return {2'b01, i[3:0]};
        end
        unique case (i)
            5'd16:   return 6'h20;
            5'd17:   return 6'h29;
            default: return 6'h27;
        endcase
    endfunction

    always_ff @(posedge clk33_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state        <= StIdle;
            pps_q        <= 1'b0;
            settle_cnt   <= '0;
            idx          <= '0;
            seq_cnt      <= '0;
            vis_bank     <= 1'b1;
            scal_addr_o  <= '0;
            snap_valid_o <= 1'b0;
            snap_seq_o   <= '0;
            busy_o       <= 1'b0;
            overrun_o    <= 1'b0;
            drop_cnt_o   <= '0;
        end else begin
            pps_q <= pps_i;
            // Edges are only accepted in IDLE; anything else is an overrun, including SWAP.
            if (pps_edge && state != StIdle) begin
                overrun_o <= 1'b1;
            end
            unique case (state)
                StIdle: begin
                    scal_addr_o <= 6'h10;
                    if (pps_edge) begin
                        settle_cnt <= 8'(SETTLE_CYCLES - 1);
                        busy_o     <= 1'b1;
                        state      <= StSettle;
                    end
                end
                StSettle: begin
                    if (settle_cnt == 8'd0) begin
                        idx   <= '0;
                        state <= StAddr;
                    end else begin
                        settle_cnt <= settle_cnt - 8'd1;
                    end
                end
                StAddr: begin
                    scal_addr_o <= word_addr(idx);
                    state       <= StCapt;
                end
                StCapt: begin
                    if (idx == 5'(NUM_WORDS - 1)) begin
                        state <= StSwap;
                    end else begin
                        idx   <= idx + 5'd1;
                        state <= StAddr;
                    end
                end
                StSwap: begin
                    seq_cnt     <= seq_cnt + 8'd1;
                    busy_o      <= 1'b0;
                    scal_addr_o <= 6'h10;
                    if (!lock_i) begin
                        vis_bank     <= ~vis_bank;
                        snap_valid_o <= 1'b1;
                        snap_seq_o   <= seq_cnt + 8'd1;
                    end else if (drop_cnt_o != 8'hFF) begin
                        drop_cnt_o <= drop_cnt_o + 8'd1;
                    end
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Write bank is always the one the host is not looking at.
    always_ff @(posedge clk33_i) begin
        if (state == StCapt) begin
            mem[{~vis_bank, idx}] <= scal_dat_i;
        end
    end

    always_ff @(posedge clk33_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_dat_o <= '0;
        end else if (rd_addr_i < 5'(NUM_WORDS)) begin
            rd_dat_o <= mem[{vis_bank, rd_addr_i}];
        end else begin
            rd_dat_o <= '0;
        end
    end

endmodule
